sipo_frame_ctrl: RTL and testbench
==================================

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: number of data bits per frame, legal range 2..32.
REQ-002 Parameter PARITY_EN, default 1: 1 means an even-parity bit follows the data; 0 means there is no parity bit.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 din  input  1  serial line; sampled only when en=1.
REQ-006 en  input  1  bit strobe; one serial bit is consumed per cycle with en=1.
REQ-007 dout  output  WIDTH  last completed frame, with the first-received bit at the MSB.
REQ-008 dout_valid  output  1  dout holds an unconsumed word.
REQ-009 dout_ready  input  1  consumer accepts dout when dout_valid=1 and dout_ready=1.
REQ-010 busy  output  1  high while the FSM is not in IDLE.
REQ-011 par_err  output  1  parity result for the word on dout; valid while dout_valid=1.
REQ-012 overrun  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-013 FSM states: IDLE, SHIFT, PARITY; state and bit counter change only on cycles with en=1 (or rst=1).
REQ-014 IDLE: en=1 and din=1 (start bit) -> SHIFT with bit counter cleared; en=1 and din=0 -> stay in IDLE.
REQ-015 SHIFT: each en=1 cycle, the shift register shifts left with din entering the LSB, and the counter increments.
REQ-016 SHIFT exit: on the en=1 cycle that shifts in the WIDTH-th bit, go to PARITY if PARITY_EN=1; otherwise go to IDLE and complete the frame.
REQ-017 PARITY: on an en=1 cycle, sample the parity bit, set error = XOR(data bits) XOR din, go to IDLE and complete the frame.
REQ-018 Completion latency: dout, par_err and dout_valid update on the clock edge of the final consuming en cycle, so they are visible the next cycle.
REQ-019 Completion with dout_valid=0, or with dout_valid=1 and dout_ready=1 in the same cycle: load the new word, dout_valid=1, overrun=0.
REQ-020 Completion with dout_valid=1 and dout_ready=0: drop the new word, keep dout and par_err unchanged, pulse overrun high for exactly one cycle.
REQ-021 Accept without completion: dout_valid falls next cycle; dout holds its value.
REQ-022 en=0 during a frame stalls the block: no shift, no count, no state change; the handshake still operates.
REQ-023 Reception of the next frame proceeds while a word is pending; the output register is a one-deep buffer.
REQ-024 A start bit is detected on the en cycle immediately after a completion; no idle gap is required.

Reset
REQ-025 rst=1 forces state=IDLE, counter=0, shift register=0, dout=0, dout_valid=0, par_err=0, overrun=0, busy=0 on the next edge.
REQ-026 rst takes priority over en and dout_ready; a partial frame interrupted by rst is discarded and no word is produced.

Structure
REQ-027 Package sipo_ctrl_pkg holds the state encoding constants and the default WIDTH/PARITY_EN values.
REQ-028 The datapath is a sub-module sipo_shift_reg (clk, rst, shift_en, din, q[WIDTH]); the controller drives shift_en and owns the counter, FSM and output buffer.

Verification (WIDTH=4, PARITY_EN=1 unless stated)
REQ-029 Frame: start, bits 1,0,1,1, parity 1, with en=1 every cycle -> dout=4'b1011, dout_valid=1 one cycle after the parity cycle, par_err=0, busy low in the same cycle.
REQ-030 Same frame with parity 0 -> dout=4'b1011, par_err=1.
REQ-031 Frame 1011 held unaccepted (dout_ready=0), then frame 0110 completes -> overrun pulses one cycle, dout stays 4'b1011; then a completion with dout_ready=1 in the same cycle loads the next word with no overrun.
REQ-032 rst=1 after two data bits, then frame 0110 with parity 0 -> no word from the aborted frame; dout=4'b0110, par_err=0.
REQ-033 en toggling 1,0,0,1,... through frame 1100 with parity 0 -> dout=4'b1100; the counter advances only on en=1 cycles.
REQ-034 PARITY_EN=0, WIDTH=8, frame start plus 8'hA5 -> dout=8'hA5 valid one cycle after the 8th data bit, par_err=0.

Source files
------------

// File: rtl/sipo_ctrl_pkg.sv
// Shared constants for the serial-in/parallel-out frame receiver:
// FSM state encoding and default frame geometry.
package sipo_ctrl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_PARITY_EN = 1;

endpackage

// File: rtl/sipo_shift_reg.sv
// Shift-left register: new serial bit enters the LSB, so the first bit
// received ends up at the MSB once WIDTH bits have been shifted in.
module sipo_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else if (shift_en) begin
      q_q <= {q_q[WIDTH-2:0], din};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame receiver controller: start-bit detection, bit counting, optional
// even-parity check and a one-deep output buffer with overrun reporting.
//
// Output handshake: a word is transferred on every rising edge where
// dout_valid=1 and dout_ready=1; dout/par_err stay stable while dout_valid=1
// and no transfer occurs; dout_valid never drops without a transfer.
module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int PARITY_EN = DEF_PARITY_EN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             par_err,
  output logic             overrun,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ovr_q, ovr_d;

  logic             shift_en;
  logic             complete;
  logic [WIDTH-1:0] word;
  logic             perr_new;
  logic [WIDTH-1:0] sr_q;

  sipo_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .din      (din),
    .q        (sr_q)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_en = 1'b0;
    complete = 1'b0;
    word     = sr_q;
    perr_new = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && din) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (en) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = ST_PARITY;
            end else begin
              // No parity stage: the word completes with the bit being shifted in now.
              state_d  = ST_IDLE;
              complete = 1'b1;
              word     = {sr_q[WIDTH-2:0], din};
            end
          end
        end
      end
      ST_PARITY: begin
        if (en) begin
          state_d  = ST_IDLE;
          complete = 1'b1;
          perr_new = (^sr_q) ^ din;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ovr_d   = 1'b0;
    if (complete) begin
      if (!valid_q || dout_ready) begin
        dout_d  = word;
        perr_d  = perr_new;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && dout_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign par_err    = perr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != ST_IDLE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Randomized and directed bench for sipo_frame_ctrl (WIDTH=4 with parity,
// plus a WIDTH=8 no-parity instance) against a frame-level reference model.
module tb_sipo_frame_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, din, en, dout_ready;
  logic [3:0] dout;
  logic       dout_valid, busy, par_err, overrun;
  logic [1:0] state_dbg;

  logic       rst8, din8, en8, ready8;
  logic [7:0] dout8;
  logic       valid8, busy8, perr8, ovr8;
  logic [1:0] state8;

  sipo_frame_ctrl #(.WIDTH(4), .PARITY_EN(1)) dut (
    .clk(clk), .rst(rst), .din(din), .en(en),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .par_err(par_err), .overrun(overrun), .state_dbg(state_dbg)
  );

  sipo_frame_ctrl #(.WIDTH(8), .PARITY_EN(0)) dut8 (
    .clk(clk), .rst(rst8), .din(din8), .en(en8),
    .dout(dout8), .dout_valid(valid8), .dout_ready(ready8),
    .busy(busy8), .par_err(perr8), .overrun(ovr8), .state_dbg(state8)
  );

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [3:0] exp_q[$];  // words the consumer is expected to receive, in order

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Frame-level model of the output buffer as seen from the pins.
  logic       m_valid, m_perr, m_ovr, m_busy;
  logic [3:0] m_word;

  task automatic model_clear();
    m_valid = 1'b0; m_perr = 1'b0; m_ovr = 1'b0; m_busy = 1'b0; m_word = '0;
  endtask

  // One clock cycle: drive, check outputs mid-cycle, advance the model.
  task automatic step(input logic r, input logic e, input logic d, input logic rdy,
                      input logic cmp, input logic [3:0] w, input logic p,
                      input logic bnext);
    rst = r; en = e; din = d; dout_ready = rdy;
    @(negedge clk);
    check("dout_valid", 32'(dout_valid), 32'(m_valid));
    if (m_valid) begin
      check("dout", 32'(dout), 32'(m_word));
      check("par_err", 32'(par_err), 32'(m_perr));
      if (rdy) begin
        check("accept_order", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("accept_word", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("busy", 32'(busy), 32'(m_busy));
    if (r) begin
      model_clear();
      exp_q.delete();
    end else begin
      m_ovr = 1'b0;
      if (cmp) begin
        if (!m_valid || rdy) begin
          m_valid = 1'b1; m_word = w; m_perr = p;
          exp_q.push_back(w);
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
      m_busy = bnext;
    end
    @(posedge clk); #1;
  endtask

  // ready modes: 0 never, 1 always, 2 random, 3 only on the completing cycle
  function automatic logic rdy_of(input int mode, input logic last);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return 1'($urandom_range(0, 1));
      default: return last;
    endcase
  endfunction

  // Start bit, data MSB-first, parity bit; stall = en=0 cycles before each
  // post-start bit (-1 picks 0..2 at random per bit).
  task automatic send_frame(input logic [3:0] w, input logic pbit, input int stall, input int rmode);
    logic [5:0] bits;
    logic       last, perr_exp;
    int         ns;
    bits = {1'b1, w, pbit};
    perr_exp = (^w) ^ pbit;  // even parity: error when total ones is odd
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        ns = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
        for (int s = 0; s < ns; s++)
          step(1'b0, 1'b0, 1'($urandom_range(0, 1)), rdy_of(rmode, 1'b0), 1'b0, w, perr_exp, 1'b1);
      end
      last = (i == 5);
      step(1'b0, 1'b1, bits[5-i], rdy_of(rmode, last), last, w, perr_exp, !last);
    end
  endtask

  task automatic idle(input int n, input int rmode);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0, rdy_of(rmode, 1'b0), 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; en = 1'b0; din = 1'b0; dout_ready = 1'b0;
    rst8 = 1'b1; en8 = 1'b0; din8 = 1'b0; ready8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);  // outputs checked as reset values next
    rst8 = 1'b0;

    // good parity, then bad parity
    send_frame(4'b1011, 1'b1, 0, 0);
    idle(2, 1);
    send_frame(4'b1011, 1'b0, 0, 0);
    idle(2, 1);

    // overrun while a word is pending, then accept-with-completion
    send_frame(4'b1011, 1'b1, 0, 0);
    send_frame(4'b0110, 1'b0, 0, 0);
    send_frame(4'b1001, 1'b0, 0, 3);
    idle(3, 1);

    // reset aborts a partial frame
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    send_frame(4'b0110, 1'b0, 0, 0);
    idle(2, 1);

    // en pattern 1,0,0,1,... through the frame
    send_frame(4'b1100, 1'b0, 2, 0);
    idle(2, 1);

    // randomized frames, gaps (including zero) and consumer behaviour
    for (int f = 0; f < 40; f++) begin
      send_frame(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), -1,
                 int'($urandom_range(0, 3)));
      idle(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
    idle(3, 1);
    check("drained", 32'(exp_q.size()), 32'd0);

    // WIDTH=8, no parity: start + 8'hA5
    begin
      logic [7:0] a5;
      a5 = 8'hA5;
      en8 = 1'b1; din8 = 1'b1;
      @(posedge clk); #1;
      for (int i = 7; i >= 0; i--) begin
        din8 = a5[i];
        @(negedge clk);
        check("w8_busy_mid", 32'(busy8), 32'd1);
        check("w8_not_early", 32'(valid8), 32'd0);
        @(posedge clk); #1;
      end
      en8 = 1'b0; din8 = 1'b0;
      @(negedge clk);
      check("w8_valid", 32'(valid8), 32'd1);
      check("w8_dout", 32'(dout8), 32'hA5);
      check("w8_par_err", 32'(perr8), 32'd0);
      check("w8_busy_done", 32'(busy8), 32'd0);
      check("w8_overrun", 32'(ovr8), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule
